aes_sub_shift: RTL and testbench
================================

Name: aes_sub_shift

Overview:
- AES round stage directly upstream of the MixColumns column multiplier.
- Accepts a 128-bit state over a valid/ready handshake and applies SubBytes using BYTES_PER_CYCLE shared S-box instances per cycle, then ShiftRows.
- Presents the result, column-major, to MixColumns and AddRoundKey over a valid/ready handshake.
- Forwards a last-round tag so the downstream stage can bypass MixColumns.

Parameters:
- BYTES_PER_CYCLE, 1, S-box lookups per cycle. Legal values: 1, 2, 4, 8, 16.
- SUB_CYCLES, 16/BYTES_PER_CYCLE, derived local constant. Not overridable.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input state valid
- in_ready  out  1  stage can accept a state
- in_state  in  128  byte k at [127-8k -: 8]; byte k is row k%4, column k/4
- in_last  in  1  final-round tag
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_state  out  128  SubBytes+ShiftRows result, same byte layout as in_state
- out_last  out  1  registered copy of in_last
- busy  out  1  high in SUB state

Behaviour:
- Reset, asynchronous on rst_n low:
  - state = IDLE, byte counter = 0, data register = 0.
  - out_valid = 0, out_last = 0, busy = 0, out_state = 0.
  - in_ready = 1 once rst_n is high.
- Clock and reset: single clock. Reset asserted mid-operation abandons the current state, with no partial output.
- States:
  - IDLE: in_ready = 1. On in_valid & in_ready, capture in_state and in_last, clear the counter, go to SUB.
  - SUB: each cycle, replace bytes [cnt*BPC .. cnt*BPC+BPC-1] of the data register with S-box(byte); cnt increments. After the cycle with cnt = SUB_CYCLES-1, go to DONE. in_ready = 0 and in_valid is ignored.
  - DONE: out_valid = 1. out_state, out_last and out_valid stay stable until out_ready.
    - On out_ready with in_valid low: go to IDLE.
    - On out_ready with in_valid high: capture the new input in the same cycle and go to SUB (back-to-back).
    - In DONE, in_ready = out_ready.
- Latency: accept edge E0; substitutions on edges E1..E_SUB_CYCLES; out_valid high from after E_SUB_CYCLES. At the default that is 16 cycles.
- Throughput: one state per SUB_CYCLES+1 cycles (17 at default), assuming out_ready is held high.
- ShiftRows:
  - Applied combinationally on the output path: out_state[row r, col c] = sub[row r, col (c+r) mod 4].
  - The data register holds un-shifted substituted bytes.
  - out_state is a pure function of registers and has no combinational path from inputs.
- out_valid drop: out_valid never drops without out_ready.
- in_ready paths: in_ready never depends combinationally on in_valid. It does depend on out_ready, but only in DONE.
- S-box: combinational 256x8 table per FIPS-197. No inverse S-box; this block is encryption only.
- Input signals when idle: in_last and in_state are don't-care when in_valid = 0.
- X handling: X on in_state outside the accept cycle must not propagate.

Decomposition:
- Package aes_pkg:
  - AES_STATE_W = 128, AES_BYTES = 16
  - byte-index helper function row/col <-> k
  - the S-box constant table
- Sub-module aes_sbox: 8-bit in -> 8-bit out, combinational, from the package table. Instantiated BYTES_PER_CYCLE times.
- The FSM, counter and ShiftRows wiring live in aes_sub_shift.

Test Plan:
1. FIPS-197 Appendix B round 1:
   - in_state = 193de3bea0f4e22b9ac68d2ae9f84808, in_last = 0 -> after 16 cycles, out_state = d4bf5d30e0b452aeb84111f11e2798e5, out_last = 0.
   - Drive out_state column 0 (d4 bf 5d 30) into MixSingleColumn -> expect 04 66 81 e5.
2. All-zero state -> out_state = 63636363636363636363636363636363. in_last = 1 -> out_last = 1.
3. Column test, bytes 0..3 = 01,03,0f,7f and others 00:
   - S-box values are 7c,7b,76,d2.
   - out_state = 7c636363636363d26363766363 7b6363 with rows shifted; row r byte lands at column (4-r) mod 4.
   - Check each byte.
4. Backpressure: hold out_ready = 0 for 10 cycles after out_valid -> out_state and out_valid stable, in_ready = 0. Then out_ready = 1 together with a new in_valid -> accepted the same cycle, and the next out_valid comes 16 cycles later.
5. Reset mid-SUB: pulse rst_n low at cycle 8 of SUB -> out_valid = 0 immediately, in_ready = 1 after release, and no stale output appears.
6. Parameter sweep: BYTES_PER_CYCLE = 4 and 16 with vector 1 -> same out_state, with latency 4 and 1 cycles respectively.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES constants, byte-layout helpers and the forward S-box table.
// Byte k of a 128-bit state sits at [127-8k -: 8]; k = 4*col + row.
package aes_pkg;

  localparam int AES_STATE_W = 128;
  localparam int AES_BYTES   = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SUB,
    ST_DONE
  } sub_st_e;

  // FIPS-197 S-box, entry 0 in the top byte
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic int byte_idx(input int row, input int col);
    return 4 * col + row;
  endfunction

  function automatic int byte_row(input int k);
    return k % 4;
  endfunction

  function automatic int byte_col(input int k);
    return k / 4;
  endfunction

  function automatic logic [7:0] sbox_lut(input logic [7:0] x);
    return SBOX[(255 - int'(x)) * 8 +: 8];
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box lookup.
// One instance per byte substituted per cycle.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);

  assign y = sbox_lut(a);

endmodule

// File: rtl/aes_sub_shift.sv
// AES SubBytes (time-shared S-boxes) followed by ShiftRows,
// feeding the MixColumns/AddRoundKey stage over valid/ready.
module aes_sub_shift
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   out_last,
  output logic                   busy
);

  localparam int SUB_CYCLES = AES_BYTES / BYTES_PER_CYCLE;
  localparam logic [3:0] CNT_LAST = 4'(SUB_CYCLES - 1);

  sub_st_e                st_q, st_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] data_q, data_d;
  logic                   last_q, last_d;

  logic [7:0] sb_in  [BYTES_PER_CYCLE];
  logic [7:0] sb_out [BYTES_PER_CYCLE];

  function automatic int sub_idx(input logic [3:0] c, input int i);
    return (int'(c) * BYTES_PER_CYCLE + i) & 15;
  endfunction

  always_comb begin
    for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
      sb_in[i] = data_q[127 - 8 * sub_idx(cnt_q, i) -: 8];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_sbox
    aes_sbox u_sbox (
      .a(sb_in[g]),
      .y(sb_out[g])
    );
  end

  assign in_ready  = (st_q == ST_IDLE) |
                     ((st_q == ST_DONE) & out_ready);
  assign out_valid = (st_q == ST_DONE);
  assign busy      = (st_q == ST_SUB);
  assign out_last  = last_q;

  always_comb begin
    st_d   = st_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    last_d = last_q;
    unique case (st_q)
      ST_IDLE: begin
        if (in_valid) begin
          st_d   = ST_SUB;
          cnt_d  = '0;
          data_d = in_state;
          last_d = in_last;
        end
      end
      ST_SUB: begin
        for (int i = 0; i < BYTES_PER_CYCLE; i++) begin
          data_d[127 - 8 * sub_idx(cnt_q, i) -: 8] = sb_out[i];
        end
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) begin
          st_d  = ST_DONE;
          cnt_d = '0;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          if (in_valid) begin
            st_d   = ST_SUB;
            cnt_d  = '0;
            data_d = in_state;
            last_d = in_last;
          end else begin
            st_d = ST_IDLE;
          end
        end
      end
      default: st_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q   <= ST_IDLE;
      cnt_q  <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      last_q <= last_d;
    end
  end

  // Register holds un-shifted bytes; rotate row r left by r here
  always_comb begin
    out_state = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        out_state[127 - 8 * byte_idx(r, c) -: 8] =
          data_q[127 - 8 * byte_idx(r, (c + r) % 4) -: 8];
      end
    end
  end

endmodule

// File: tb/tb_aes_sub_shift.sv
// Directed vector bench for aes_sub_shift at 1, 4 and 16 S-boxes.
// Reference values come from FIPS-197 and hand-applied ShiftRows.
module tb_aes_sub_shift;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_last = 1'b0;
  logic [127:0] in_state = '0;
  logic         out_ready = 1'b0;
  logic         sw_ready = 1'b0;

  logic         in_ready, out_valid, out_last, busy;
  logic [127:0] out_state;
  logic         r4, v4, l4, b4;
  logic [127:0] s4;
  logic         r16, v16, l16, b16;
  logic [127:0] s16;

  always #5 clk = ~clk;

  aes_sub_shift #(.BYTES_PER_CYCLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .out_last(out_last),
    .busy(busy)
  );

  aes_sub_shift #(.BYTES_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r4),
    .in_state(in_state), .in_last(in_last),
    .out_valid(v4), .out_ready(sw_ready),
    .out_state(s4), .out_last(l4),
    .busy(b4)
  );

  aes_sub_shift #(.BYTES_PER_CYCLE(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(r16),
    .in_state(in_state), .in_last(in_last),
    .out_valid(v16), .out_ready(sw_ready),
    .out_state(s16), .out_last(l16),
    .busy(b16)
  );

  typedef struct {
    logic [127:0] s;
    logic         l;
    logic [127:0] e;
  } vec_t;

  vec_t v [4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [127:0] got,
                     input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [127:0] s, input logic l);
    int n = 0;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    chk("send_ready", 128'(in_ready), 128'(1));
    in_state = s;
    in_last  = l;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_state = 'x;
    in_last  = 1'bx;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = c;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  initial begin
    int n, lat1, lat4, lat16, seen;

    v[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
             128'hd4bf5d30e0b452aeb84111f11e2798e5};
    v[1] = '{128'h0, 1'b1,
             128'h63636363636363636363636363636363};
    v[2] = '{128'h01030f7f000000000000000000000000, 1'b0,
             128'h7c636363636363d263637663637b6363};
    v[3] = '{{128{1'b1}}, 1'b1,
             128'h16161616161616161616161616161616};

    tick();
    tick();
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_out_state", out_state, 128'h0);
    chk("rst_out_last", 128'(out_last), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Parameter sweep: all three instances take the same state
    send(v[0].s, v[0].l);
    lat1 = 0;
    lat4 = 0;
    lat16 = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (out_valid && lat1 == 0) lat1 = k;
      if (v4 && lat4 == 0) lat4 = k;
      if (v16 && lat16 == 0) lat16 = k;
    end
    chk("lat_bpc1", 128'(lat1), 128'(16));
    chk("lat_bpc4", 128'(lat4), 128'(4));
    chk("lat_bpc16", 128'(lat16), 128'(1));
    chk("state_bpc1", out_state, v[0].e);
    chk("state_bpc4", s4, v[0].e);
    chk("state_bpc16", s16, v[0].e);
    out_ready = 1'b1;
    sw_ready  = 1'b1;
    tick();
    out_ready = 1'b0;

    for (int i = 0; i < 4; i++) begin
      send(v[i].s, v[i].l);
      chk($sformatf("v%0d_busy", i), 128'(busy), 128'(1));
      wait_valid(n);
      chk($sformatf("v%0d_latency", i), 128'(n), 128'(16));
      chk($sformatf("v%0d_state", i), out_state, v[i].e);
      chk($sformatf("v%0d_last", i), 128'(out_last), 128'(v[i].l));
      if (i == 0) begin
        chk("mix_col0", 128'(mix_col(out_state[127:96])),
            128'(32'h046681e5));
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk($sformatf("v%0d_released", i), 128'(out_valid), 128'(0));
    end

    // Backpressure with a new state waiting
    send(v[0].s, v[0].l);
    wait_valid(n);
    chk("bp_first_latency", 128'(n), 128'(16));
    in_state = v[1].s;
    in_last  = v[1].l;
    in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_state", out_state, v[0].e);
      chk("bp_hold_last", 128'(out_last), 128'(0));
      chk("bp_hold_in_ready", 128'(in_ready), 128'(0));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_follow", 128'(in_ready), 128'(1));
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    in_state  = 'x;
    chk("bp_b2b_valid_drop", 128'(out_valid), 128'(0));
    chk("bp_b2b_busy", 128'(busy), 128'(1));
    wait_valid(n);
    chk("bp_b2b_latency", 128'(n), 128'(16));
    chk("bp_b2b_state", out_state, v[1].e);
    chk("bp_b2b_last", 128'(out_last), 128'(1));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SUB
    send(v[2].s, v[2].l);
    repeat (8) tick();
    chk("mid_busy", 128'(busy), 128'(1));
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_busy", 128'(busy), 128'(0));
    chk("mid_rst_state", out_state, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("mid_in_ready", 128'(in_ready), 128'(1));
    seen = 0;
    for (int k = 0; k < 30; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("mid_no_stale", 128'(seen), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
